// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one byte-wide UART transmitter between N byte sources. Round-robin
// arbitration on release, optional per-requester lock for contiguous
// multi-byte messages, and a watchdog that frees a lock held by an idle owner.
module uart_tx_arbiter #(
   parameter int N            = 4,
   parameter int LOCK_TIMEOUT = 40000,
   parameter int TW           = 16
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic [N-1:0]   req_i,
   input  logic [8*N-1:0] data_i,
   input  logic [N-1:0]   lock_i,
   output logic [N-1:0]   ack_o,
   output logic [N-1:0]   grant_o,
   output logic           tx_valid_o,
   output logic [7:0]     tx_data_o,
   input  logic           tx_ready_i,
   output logic           busy_o,
   output logic           timeout_o
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   // Last counter value before a forced release; unused when the watchdog is off.
   localparam logic [TW-1:0] TO_LAST = (LOCK_TIMEOUT > 0) ? TW'(LOCK_TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_ACK, S_OWN} state_t;

   state_t         state_q, state_d;
   logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]  owner_q, owner_d;
   logic [TW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   grant_q, grant_d;
   logic [N-1:0]   ack_q, ack_d;
   logic           tx_valid_q, tx_valid_d;
   logic [7:0]     tx_data_q, tx_data_d;
   logic           busy_q, busy_d;
   logic           timeout_q, timeout_d;

   logic           win_found;
   logic [PW-1:0]  win_idx;
   logic [PW-1:0]  scan_idx;

   // Pointer increment with explicit wrap so non-power-of-2 N works.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(N - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   function automatic logic [N-1:0] onehot(input logic [PW-1:0] p);
      logic [N-1:0] v;
      v    = '0;
      v[p] = 1'b1;
      return v;
   endfunction

   function automatic logic [7:0] pick_byte(input logic [8*N-1:0] d, input logic [PW-1:0] p);
      return d[{p, 3'b000} +: 8];
   endfunction

   // Round-robin winner: first active request scanning from rr_ptr upward.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = rr_ptr_q;
      for (int i = 0; i < N; i++) begin
         if (!win_found && req_i[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
         scan_idx = ptr_inc(scan_idx);
      end
   end

   // Next-state and registered-output logic for the arbitration FSM.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      grant_d    = grant_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      ack_d      = '0;
      timeout_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               owner_d    = win_idx;
               grant_d    = onehot(win_idx);
               tx_data_d  = pick_byte(data_i, win_idx);
               tx_valid_d = 1'b1;
               state_d    = S_SEND;
            end
         end
         S_SEND: begin
            // Byte is latched; only the transmitter handshake matters here.
            if (tx_ready_i) begin
               tx_valid_d = 1'b0;
               ack_d      = onehot(owner_q);
               state_d    = S_ACK;
            end
         end
         S_ACK: begin
            cnt_d   = '0;
            state_d = S_OWN;
         end
         S_OWN: begin
            if (!lock_i[owner_q]) begin
               rr_ptr_d = ptr_inc(owner_q);
               grant_d  = '0;
               cnt_d    = '0;
               state_d  = S_IDLE;
            end else if (req_i[owner_q]) begin
               tx_data_d  = pick_byte(data_i, owner_q);
               tx_valid_d = 1'b1;
               cnt_d      = '0;
               state_d    = S_SEND;
            end else if ((LOCK_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
               // Owner held the lock too long without sending: force release.
               rr_ptr_d  = ptr_inc(owner_q);
               grant_d   = '0;
               cnt_d     = '0;
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         cnt_q      <= '0;
         grant_q    <= '0;
         ack_q      <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         grant_q    <= grant_d;
         ack_q      <= ack_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_d;
      end
   end

   assign ack_o      = ack_q;
   assign grant_o    = grant_q;
   assign tx_valid_o = tx_valid_q;
   assign tx_data_o  = tx_data_q;
   assign busy_o     = busy_q;
   assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus a randomized
// message-level run checked against a reference arbitration model.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int LT = 16;

   logic           clk_i = 1'b0;
   logic           rst_i;
   logic [N-1:0]   req_i;
   logic [8*N-1:0] data_i;
   logic [N-1:0]   lock_i;
   logic [N-1:0]   ack_o;
   logic [N-1:0]   grant_o;
   logic           tx_valid_o;
   logic [7:0]     tx_data_o;
   logic           tx_ready_i;
   logic           busy_o;
   logic           timeout_o;

   int n_cmp = 0;
   int n_bad = 0;

   int         order_q[$];
   int         rec_src[$];
   logic [7:0] rec_byte[$];

   logic [7:0] mb [N][3][3];
   int         mlen [N][3];
   int         nmsg [N];
   int         cur_m [N];
   int         cur_b [N];
   bit         started [N];
   int         exp_src[$];
   logic [7:0] exp_byte[$];

   uart_tx_arbiter #(.N(N), .LOCK_TIMEOUT(LT), .TW(16)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .req_i      (req_i),
      .data_i     (data_i),
      .lock_i     (lock_i),
      .ack_o      (ack_o),
      .grant_o    (grant_o),
      .tx_valid_o (tx_valid_o),
      .tx_data_o  (tx_data_o),
      .tx_ready_i (tx_ready_i),
      .busy_o     (busy_o),
      .timeout_o  (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic int oh2i(input logic [N-1:0] v);
      for (int k = 0; k < N; k++) begin
         if (v[k]) return k;
      end
      return -1;
   endfunction

   task automatic do_reset();
      rst_i      = 1'b1;
      req_i      = '0;
      data_i     = '0;
      lock_i     = '0;
      tx_ready_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   // Lowers each requester's req on its ack and records ack order until idle.
   task automatic drain();
      order_q.delete();
      for (int c = 0; c < 200 && (req_i != '0 || busy_o); c++) begin
         tick();
         for (int k = 0; k < N; k++) begin
            if (ack_o[k]) begin
               order_q.push_back(k);
               req_i[k]  = 1'b0;
               lock_i[k] = 1'b0;
            end
         end
      end
   endtask

   task automatic run_order(input logic [N-1:0] mask);
      for (int k = 0; k < N; k++) data_i[8*k +: 8] = 8'h10 + 8'(k);
      lock_i     = '0;
      tx_ready_i = 1'b1;
      req_i      = mask;
      drain();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({tx_valid_o, tx_data_o, ack_o, grant_o, busy_o, timeout_o} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got v=%b d=%h ack=%b gnt=%b busy=%b to=%b, expected all zero",
                  tx_valid_o, tx_data_o, ack_o, grant_o, busy_o, timeout_o);
      end
   endtask

   task automatic test_single();
      req_i = 4'b0001; data_i[7:0] = 8'h56; tx_ready_i = 1'b1; lock_i = '0;
      tick();
      n_cmp++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h56 || grant_o !== 4'b0001 || busy_o !== 1'b1) begin
         n_bad++;
         $display("FAIL single_send: got v=%b d=%h gnt=%b busy=%b, expected v=1 d=56 gnt=0001 busy=1",
                  tx_valid_o, tx_data_o, grant_o, busy_o);
      end
      tick();
      n_cmp++;
      if (ack_o !== 4'b0001 || tx_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL single_ack: got ack=%b v=%b, expected ack=0001 v=0", ack_o, tx_valid_o);
      end
      req_i = '0;
      tick();
      n_cmp++;
      if (ack_o !== 4'b0000) begin
         n_bad++;
         $display("FAIL single_ack_pulse: got ack=%b, expected 0000", ack_o);
      end
      tick();
      n_cmp++;
      if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL single_idle: got gnt=%b busy=%b, expected gnt=0000 busy=0", grant_o, busy_o);
      end
      // rr_ptr is now 1, so requester 1 beats requester 0.
      run_order(4'b0011);
      n_cmp++;
      if (order_q.size() != 2 || order_q[0] != 1 || order_q[1] != 0) begin
         n_bad++;
         $display("FAIL single_ptr_after: got %p, expected '{1,0}", order_q);
      end
   endtask

   task automatic test_round_robin();
      run_order(4'b1000);
      n_cmp++;
      if (order_q.size() != 1 || order_q[0] != 3) begin
         n_bad++;
         $display("FAIL rr_wrap_setup: got %p, expected '{3}", order_q);
      end
      run_order(4'b1111);
      n_cmp++;
      if (order_q.size() != 4 || order_q[0] != 0 || order_q[1] != 1 || order_q[2] != 2 || order_q[3] != 3) begin
         n_bad++;
         $display("FAIL rr_all_four: got %p, expected '{0,1,2,3}", order_q);
      end
      run_order(4'b1001);
      n_cmp++;
      if (order_q.size() != 2 || order_q[0] != 0 || order_q[1] != 3) begin
         n_bad++;
         $display("FAIL rr_ptr0: got %p, expected '{0,3}", order_q);
      end
      run_order(4'b0001);
      run_order(4'b1001);
      n_cmp++;
      if (order_q.size() != 2 || order_q[0] != 3 || order_q[1] != 0) begin
         n_bad++;
         $display("FAIL rr_ptr1: got %p, expected '{3,0}", order_q);
      end
   endtask

   task automatic test_backpressure();
      int acks;
      int wrong;
      req_i = 4'b0010; data_i[15:8] = 8'h9A; tx_ready_i = 1'b0; lock_i = '0;
      tick();
      n_cmp++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h9A || grant_o !== 4'b0010) begin
         n_bad++;
         $display("FAIL bp_first: got v=%b d=%h gnt=%b, expected v=1 d=9a gnt=0010", tx_valid_o, tx_data_o, grant_o);
      end
      for (int c = 0; c < 100; c++) begin
         tick();
         n_cmp++;
         if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h9A || ack_o !== 4'b0000) begin
            n_bad++;
            $display("FAIL bp_hold cycle %0d: got v=%b d=%h ack=%b, expected v=1 d=9a ack=0000",
                     c, tx_valid_o, tx_data_o, ack_o);
         end
      end
      tx_ready_i = 1'b1;
      acks = 0; wrong = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (ack_o != '0) begin
            acks++;
            if (ack_o !== 4'b0010) wrong++;
            req_i = '0;
         end
      end
      n_cmp++;
      if (acks != 1 || wrong != 0) begin
         n_bad++;
         $display("FAIL bp_ack_count: got %0d acks (%0d wrong), expected 1 ack on requester 1", acks, wrong);
      end
   endtask

   task automatic test_lock_burst();
      int nb2;
      int es[4];
      logic [7:0] eb[4];
      es = '{2, 2, 2, 0};
      eb = '{8'h41, 8'h42, 8'h43, 8'h30};
      rec_src.delete(); rec_byte.delete();
      nb2 = 0;
      tx_ready_i = 1'b1;
      data_i[23:16] = 8'h41; data_i[7:0] = 8'h30;
      lock_i = 4'b0100;
      req_i  = 4'b0101;
      for (int c = 0; c < 80 && (req_i != '0 || busy_o); c++) begin
         tick();
         if (tx_valid_o && tx_ready_i) begin
            rec_src.push_back(oh2i(grant_o));
            rec_byte.push_back(tx_data_o);
         end
         if (ack_o[2]) begin
            nb2++;
            if (nb2 < 3) data_i[23:16] = 8'h41 + 8'(nb2);
            else begin req_i[2] = 1'b0; lock_i[2] = 1'b0; end
         end
         if (ack_o[0]) req_i[0] = 1'b0;
      end
      n_cmp++;
      if (rec_src.size() != 4) begin
         n_bad++;
         $display("FAIL burst_len: got %0d transfers, expected 4", rec_src.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rec_src[i] != es[i] || rec_byte[i] !== eb[i]) begin
               n_bad++;
               $display("FAIL burst_item %0d: got src=%0d byte=%h, expected src=%0d byte=%h",
                        i, rec_src[i], rec_byte[i], es[i], eb[i]);
            end
         end
      end
   endtask

   task automatic test_lock_timeout();
      int got_ack;
      tx_ready_i = 1'b1;
      data_i[15:8] = 8'h77; data_i[31:24] = 8'h33; data_i[7:0] = 8'h30;
      lock_i = 4'b0010;
      req_i  = 4'b1011;
      got_ack = 0;
      for (int c = 0; c < 20 && got_ack == 0; c++) begin
         tick();
         if (ack_o[1]) begin
            got_ack = 1;
            req_i[1] = 1'b0;
         end
      end
      n_cmp++;
      if (got_ack == 0) begin
         n_bad++;
         $display("FAIL to_first_ack: got no ack for requester 1 within 20 cycles, expected one");
      end
      for (int i = 1; i <= 18; i++) begin
         tick();
         n_cmp++;
         if (timeout_o !== (i == 17)) begin
            n_bad++;
            $display("FAIL to_pulse at OWN+%0d: got timeout=%b, expected %b", i, timeout_o, (i == 17));
         end
         if (i == 16) begin
            n_cmp++;
            if (grant_o !== 4'b0010) begin
               n_bad++;
               $display("FAIL to_held_grant: got %b, expected 0010", grant_o);
            end
         end
         if (i == 17) begin
            n_cmp++;
            if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin
               n_bad++;
               $display("FAIL to_release: got gnt=%b busy=%b, expected gnt=0000 busy=0", grant_o, busy_o);
            end
         end
         if (i == 18) begin
            n_cmp++;
            if (grant_o !== 4'b1000 || tx_data_o !== 8'h33) begin
               n_bad++;
               $display("FAIL to_next_grant: got gnt=%b d=%h, expected gnt=1000 d=33", grant_o, tx_data_o);
            end
         end
      end
      lock_i[1] = 1'b0;
      drain();
      n_cmp++;
      if (order_q.size() != 2 || order_q[0] != 3 || order_q[1] != 0) begin
         n_bad++;
         $display("FAIL to_drain: got %p, expected '{3,0}", order_q);
      end
   endtask

   task automatic test_reset_mid_send();
      run_order(4'b0100);
      req_i = 4'b0001; data_i[7:0] = 8'hC3; tx_ready_i = 1'b0; lock_i = '0;
      tick();
      rst_i = 1'b1;
      tick();
      n_cmp++;
      if (tx_valid_o !== 1'b0 || grant_o !== 4'b0000 || busy_o !== 1'b0 || ack_o !== 4'b0000 || tx_data_o !== 8'h00) begin
         n_bad++;
         $display("FAIL rst_mid_send: got v=%b gnt=%b busy=%b ack=%b d=%h, expected all zero",
                  tx_valid_o, grant_o, busy_o, ack_o, tx_data_o);
      end
      rst_i = 1'b0;
      req_i = 4'b1100; data_i[23:16] = 8'h5A; data_i[31:24] = 8'hA5; tx_ready_i = 1'b1;
      tick();
      n_cmp++;
      if (grant_o !== 4'b0100 || tx_valid_o !== 1'b1 || tx_data_o !== 8'h5A) begin
         n_bad++;
         $display("FAIL rst_regrant: got gnt=%b v=%b d=%h, expected gnt=0100 v=1 d=5a", grant_o, tx_valid_o, tx_data_o);
      end
      drain();
      n_cmp++;
      if (order_q.size() != 2 || order_q[0] != 2 || order_q[1] != 3) begin
         n_bad++;
         $display("FAIL rst_drain: got %p, expected '{2,3}", order_q);
      end
   endtask

   task automatic test_random();
      int rem[N];
      int ptr, left, w, tout_seen, cidx;
      logic [N-1:0] eg;
      do_reset();
      exp_src.delete(); exp_byte.delete();
      left = 0;
      for (int k = 0; k < N; k++) begin
         nmsg[k] = $urandom_range(0, 3);
         for (int m = 0; m < 3; m++) begin
            mlen[k][m] = $urandom_range(1, 3);
            for (int b = 0; b < 3; b++) mb[k][m][b] = 8'($urandom);
         end
         left += nmsg[k];
      end
      if (left == 0) begin nmsg[0] = 1; left = 1; end
      // Message-level model: each release re-arbitrates among requesters
      // that still have messages, scanning from the one after the last owner.
      ptr = 0;
      for (int k = 0; k < N; k++) rem[k] = 0;
      while (left > 0) begin
         w = -1;
         for (int i = 0; i < N; i++) begin
            cidx = (ptr + i) % N;
            if (w < 0 && rem[cidx] < nmsg[cidx]) w = cidx;
         end
         for (int b = 0; b < mlen[w][rem[w]]; b++) begin
            exp_src.push_back(w);
            exp_byte.push_back(mb[w][rem[w]][b]);
         end
         rem[w]++;
         left--;
         ptr = (w + 1) % N;
      end
      for (int k = 0; k < N; k++) begin
         cur_m[k] = 0; cur_b[k] = 0; started[k] = 1'b0;
         req_i[k] = (nmsg[k] > 0);
         data_i[8*k +: 8] = mb[k][0][0];
      end
      lock_i = '0;
      tout_seen = 0;
      for (int c = 0; c < 5000; c++) begin
         if (exp_src.size() == 0 && req_i == '0 && !busy_o) break;
         tick();
         tx_ready_i = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < N; k++) begin
            if (grant_o[k] && tx_valid_o && !started[k]) begin
               started[k] = 1'b1;
               lock_i[k]  = (mlen[k][cur_m[k]] > 1);
            end
         end
         if (tx_valid_o && tx_ready_i) begin
            n_cmp++;
            if (exp_src.size() == 0) begin
               n_bad++;
               $display("FAIL rand_extra: got byte %h from gnt=%b, expected no transfer", tx_data_o, grant_o);
            end else begin
               eg = '0;
               eg[exp_src[0]] = 1'b1;
               if (grant_o !== eg || tx_data_o !== exp_byte[0]) begin
                  n_bad++;
                  $display("FAIL rand_xfer: got gnt=%b byte=%h, expected gnt=%b byte=%h",
                           grant_o, tx_data_o, eg, exp_byte[0]);
               end
               void'(exp_src.pop_front());
               void'(exp_byte.pop_front());
            end
         end
         if (timeout_o) tout_seen++;
         for (int k = 0; k < N; k++) begin
            if (ack_o[k]) begin
               cur_b[k]++;
               if (cur_b[k] < mlen[k][cur_m[k]]) begin
                  data_i[8*k +: 8] = mb[k][cur_m[k]][cur_b[k]];
               end else begin
                  cur_m[k]++;
                  cur_b[k]   = 0;
                  started[k] = 1'b0;
                  lock_i[k]  = 1'b0;
                  if (cur_m[k] < nmsg[k]) data_i[8*k +: 8] = mb[k][cur_m[k]][0];
                  else req_i[k] = 1'b0;
               end
            end
         end
      end
      n_cmp++;
      if (exp_src.size() != 0) begin
         n_bad++;
         $display("FAIL rand_drain: got %0d bytes still outstanding, expected 0", exp_src.size());
      end
      n_cmp++;
      if (tout_seen != 0) begin
         n_bad++;
         $display("FAIL rand_no_timeout: got %0d timeout pulses, expected 0", tout_seen);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_lock_burst();
      test_lock_timeout();
      test_reset_mid_send();
      for (int r = 0; r < 4; r++) test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
